alarm_key_ctrl: RTL
===================

# alarm_key_ctrl

Keypad-entry controller for the alarm clock. It decodes key presses and assembles a 4-digit HH:MM entry in a shift buffer. It validates the entry and issues one-cycle load strobes to the alarm register (`load_new_alarm`) or the current-time counter (`load_new_time`), and it selects what the display shows. It sits between the keypad scanner and the alarm/time registers, and its digit outputs feed their `new_*` inputs directly.

## Interface
- `TIMEOUT_SEC`, default 10: number of `one_second` ticks without a key before an entry or alarm view is abandoned.
- `clock`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `one_second`, input, 1: one-cycle tick, once per second.
- `key_valid`, input, 1: one-cycle strobe marking that `key` holds a new press.
- `key`, input, 4: key code. 0–9 are digits, 4'hA is ALARM, 4'hB is TIME, and 4'hC–4'hF are ignored.
- `new_ms_hr`, `new_ls_hr`, `new_ms_min`, `new_ls_min`, output, 4 each: key-buffer digits (BCD).
- `load_new_alarm`, output, 1: one-cycle strobe to the alarm register.
- `load_new_time`, output, 1: one-cycle strobe to the time counter.
- `show_new_time`, output, 1: display shows the key buffer.
- `show_alarm`, output, 1: display shows the stored alarm.
- `entry_error`, output, 1: one-cycle strobe when a load is rejected.

## Operation
- States: SHOW_TIME, KEY_ENTRY, SHOW_ALARM, LOAD_ALARM, LOAD_TIME. Outputs are registered and Moore-decoded from state, except `entry_error`, which is a registered pulse.
- Internal registers:
  - digit count `cnt`, 0..4, saturating.
  - inactivity timer `tmr`, width $clog2(TIMEOUT_SEC+1).
- A digit shift means: ms_hr←ls_hr, ls_hr←ms_min, ms_min←ls_min, ls_min←key.
- SHOW_TIME:
  - digit: buffer cleared, then the digit is shifted in; `cnt`=1, `tmr`=0, go to KEY_ENTRY.
  - ALARM: `tmr`=0, go to SHOW_ALARM.
  - TIME and ignored codes: no effect.
- KEY_ENTRY (`show_new_time`=1):
  - digit: shift the digit in, `cnt`=min(`cnt`+1,4), `tmr`=0. Digits beyond the 4th keep shifting, so the last four entered win.
  - ALARM: if the entry is valid, go to LOAD_ALARM. Otherwise pulse `entry_error`, stay in KEY_ENTRY, and set `tmr`=0.
  - TIME: same as ALARM, but the target is LOAD_TIME.
  - The entry is valid when all of the following hold: `cnt`==4; ms_hr≤2; ms_hr<2 or ls_hr≤3; ms_min≤5.
  - ignored codes: `tmr`=0 only.
- LOAD_ALARM: `load_new_alarm`=1 for exactly one cycle, then go to SHOW_TIME. Keys arriving in this cycle are dropped.
- LOAD_TIME: the same, using `load_new_time`.
- SHOW_ALARM (`show_alarm`=1): any `key_valid` is consumed, not acted on, and returns to SHOW_TIME.
- Timeout: applies in KEY_ENTRY and SHOW_ALARM only.
  - A `one_second` tick with `tmr`==TIMEOUT_SEC-1 and no `key_valid` goes to SHOW_TIME. If the state was KEY_ENTRY, the buffer is cleared to 0 and `cnt`=0.
  - Otherwise each `one_second` tick increments `tmr`.
- Simultaneous `key_valid` and `one_second`: the key wins and `tmr`=0.
- The buffer holds its value after a load; the next entry clears it.
- Outside KEY_ENTRY and SHOW_ALARM, `tmr` is held at 0.

## Timing
- Reset asserted (async, low):
  - state = SHOW_TIME, buffer = 0000, `cnt` = 0, `tmr` = 0.
  - All strobes and `show_*` outputs are 0.
  - Reset in any state, including mid-LOAD, aborts without completing the strobe.
- Deassertion is synchronous to `clock`. The first active edge after it samples inputs.
- Latency:
  - a key sampled at edge N updates the buffer, state and `show_*` outputs after edge N.
  - a load key at edge N asserts the `load_*` strobe during cycle N+1 only. Digits are stable during that cycle.
  - SHOW_TIME returns at edge N+1.
- `entry_error` is asserted in cycle N+1 only.
- Both load strobes are never high together.

## Test plan
- Entry and alarm load:
  - After reset, check all outputs are 0.
  - Keys 0,7,3,0 then ALARM: digits 0/7/3/0 and `show_new_time`=1 after the 4th key, then `load_new_alarm`=1 for one cycle, then SHOW_TIME with `show_new_time`=0.
- Validation:
  - Keys 2,4,0,0 then TIME: `entry_error` pulses, no load, state stays KEY_ENTRY.
  - Then keys 2,3,5,9, TIME: `load_new_time` pulses.
  - Keys 1,2,6,0, ALARM: error (ms_min=6).
- Partial entry and overflow:
  - Keys 1,2 then ALARM: error (`cnt`=2).
  - Keys 1,2,3,4,5 then ALARM: digits 2/3/4/5 are loaded.
- Timeout:
  - Key 5, then TIMEOUT_SEC ticks with no key: SHOW_TIME with buffer 0000.
  - Key 5, then TIMEOUT_SEC-1 ticks, then key 1 in the same cycle as a tick: stays in KEY_ENTRY with `tmr`=0.
- Alarm view:
  - ALARM from SHOW_TIME: `show_alarm`=1. Key 3 returns to SHOW_TIME with buffer unchanged.
  - ALARM again, then TIMEOUT_SEC ticks: `show_alarm`=0.
- Reset mid-operation: assert `reset` low asynchronously during KEY_ENTRY after 3 digits, and again in the LOAD_ALARM cycle. All outputs go to 0 immediately, with no load strobe.

Source files
------------

// File: rtl/alarm_key_ctrl.sv
// Keypad-entry controller for the alarm clock: assembles an HH:MM
// entry, validates it and strobes it into the alarm or time register.
module alarm_key_ctrl #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       show_alarm,
    output logic       entry_error
);

    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_ENTRY,
        SHOW_ALARM,
        LOAD_ALARM,
        LOAD_TIME
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    ms_hr_nx, ls_hr_nx, ms_min_nx, ls_min_nx;
    logic [2:0]    cnt, cnt_nx;
    logic [TW-1:0] tmr, tmr_nx;
    logic          err_nx;

    logic is_digit, is_alarm, is_time;
    logic entry_ok, expired;

    assign is_digit = (key <= 4'd9);
    assign is_alarm = (key == 4'hA);
    assign is_time  = (key == 4'hB);

    // 00:00..23:59 only, and only once four digits have been entered
    assign entry_ok = (cnt == 3'd4) && (new_ms_hr <= 4'd2)
                   && ((new_ms_hr < 4'd2) || (new_ls_hr <= 4'd3))
                   && (new_ms_min <= 4'd5);

    // a key in the same cycle as the last tick keeps the view alive
    assign expired = one_second && !key_valid
                  && (tmr == TW'(TIMEOUT_SEC - 1));

    // next-state, buffer, counter and timer decode
    always_comb begin
        state_nx  = state;
        ms_hr_nx  = new_ms_hr;
        ls_hr_nx  = new_ls_hr;
        ms_min_nx = new_ms_min;
        ls_min_nx = new_ls_min;
        cnt_nx    = cnt;
        tmr_nx    = tmr;
        err_nx    = 1'b0;
        case (state)
            SHOW_TIME: begin
                tmr_nx = '0;
                if (key_valid && is_digit) begin
                    ms_hr_nx  = 4'd0;
                    ls_hr_nx  = 4'd0;
                    ms_min_nx = 4'd0;
                    ls_min_nx = key;
                    cnt_nx    = 3'd1;
                    state_nx  = KEY_ENTRY;
                end else if (key_valid && is_alarm) begin
                    state_nx = SHOW_ALARM;
                end
            end
            KEY_ENTRY: begin
                if (key_valid) begin
                    tmr_nx = '0;
                    if (is_digit) begin
                        ms_hr_nx  = new_ls_hr;
                        ls_hr_nx  = new_ms_min;
                        ms_min_nx = new_ls_min;
                        ls_min_nx = key;
                        cnt_nx    = (cnt == 3'd4) ? 3'd4 : cnt + 3'd1;
                    end else if (is_alarm || is_time) begin
                        if (entry_ok)
                            state_nx = is_alarm ? LOAD_ALARM : LOAD_TIME;
                        else
                            err_nx = 1'b1;
                    end
                end else if (expired) begin
                    state_nx  = SHOW_TIME;
                    ms_hr_nx  = 4'd0;
                    ls_hr_nx  = 4'd0;
                    ms_min_nx = 4'd0;
                    ls_min_nx = 4'd0;
                    cnt_nx    = 3'd0;
                    tmr_nx    = '0;
                end else if (one_second) begin
                    tmr_nx = tmr + TW'(1);
                end
            end
            SHOW_ALARM: begin
                if (key_valid) begin
                    state_nx = SHOW_TIME;
                    tmr_nx   = '0;
                end else if (expired) begin
                    state_nx = SHOW_TIME;
                    tmr_nx   = '0;
                end else if (one_second) begin
                    tmr_nx = tmr + TW'(1);
                end
            end
            LOAD_ALARM, LOAD_TIME: begin
                state_nx = SHOW_TIME;
                tmr_nx   = '0;
            end
            default: begin
                state_nx = SHOW_TIME;
                tmr_nx   = '0;
            end
        endcase
    end

    // state, datapath and registered Moore outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= SHOW_TIME;
            new_ms_hr      <= 4'd0;
            new_ls_hr      <= 4'd0;
            new_ms_min     <= 4'd0;
            new_ls_min     <= 4'd0;
            cnt            <= 3'd0;
            tmr            <= '0;
            entry_error    <= 1'b0;
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            show_new_time  <= 1'b0;
            show_alarm     <= 1'b0;
        end else begin
            state          <= state_nx;
            new_ms_hr      <= ms_hr_nx;
            new_ls_hr      <= ls_hr_nx;
            new_ms_min     <= ms_min_nx;
            new_ls_min     <= ls_min_nx;
            cnt            <= cnt_nx;
            tmr            <= tmr_nx;
            entry_error    <= err_nx;
            load_new_alarm <= (state_nx == LOAD_ALARM);
            load_new_time  <= (state_nx == LOAD_TIME);
            show_new_time  <= (state_nx == KEY_ENTRY);
            show_alarm     <= (state_nx == SHOW_ALARM);
        end
    end

endmodule
